// File: rtl/fft_result_capture.sv
// Captures one sync-aligned FFT output frame into a local buffer and drains it
// over a valid/ready stream, optionally in bit-reversed address order.
module fft_result_capture #(
    parameter int unsigned OW     = 20,
    parameter int unsigned LGFFT  = 6,
    parameter int unsigned BITREV = 0
) (
    input  logic            S_AXI_ACLK,
    input  logic            S_AXI_ARESETN,
    input  logic            i_arm,
    input  logic            i_ce,
    input  logic [2*OW-1:0] i_result,
    input  logic            i_sync,
    output logic            o_tvalid,
    input  logic            i_tready,
    output logic [2*OW-1:0] o_tdata,
    output logic            o_tlast,
    output logic            o_busy,
    output logic            o_sync_err,
    output logic            o_overrun,
    output logic [15:0]     o_frame_count
);
    localparam int unsigned N  = 1 << LGFFT;
    localparam int unsigned DW = 2 * OW;
    localparam logic [LGFFT-1:0] LAST_ADDR = LGFFT'(N - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, CAPTURE, DRAIN} state_t;

    state_t           r_state;
    logic [LGFFT-1:0] r_wptr;
    logic [LGFFT-1:0] r_k;
    logic             r_fetch_done;
    logic [DW-1:0]    r_mem [N];

    logic             w_we;
    logic [LGFFT-1:0] w_waddr;
    logic [LGFFT-1:0] w_raddr;
    logic             w_xfer;
    logic             w_fetch;

    function automatic logic [LGFFT-1:0] bitrev(input logic [LGFFT-1:0] a);
        logic [LGFFT-1:0] r;
        for (int i = 0; i < int'(LGFFT); i++) begin
            r[i] = a[LGFFT-1-i];
        end
        return r;
    endfunction

    // Write/read addressing and the prefetch condition for the output register.
    always_comb begin
        w_we    = i_ce && (((r_state == WAIT_SYNC) && i_sync) || (r_state == CAPTURE));
        w_waddr = i_sync ? '0 : r_wptr;
        w_raddr = (BITREV != 0) ? bitrev(r_k) : r_k;
        w_xfer  = o_tvalid && i_tready;
        w_fetch = (r_state == DRAIN) && !r_fetch_done && (!o_tvalid || w_xfer);
    end

    // Frame buffer: not reset, one write port.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_we) begin
            r_mem[w_waddr] <= i_result;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= IDLE;
            r_wptr        <= '0;
            r_k           <= '0;
            r_fetch_done  <= 1'b0;
            o_tvalid      <= 1'b0;
            o_tdata       <= '0;
            o_tlast       <= 1'b0;
            o_busy        <= 1'b0;
            o_sync_err    <= 1'b0;
            o_overrun     <= 1'b0;
            o_frame_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_arm) begin
                        r_state    <= WAIT_SYNC;
                        r_wptr     <= '0;
                        o_busy     <= 1'b1;
                        o_sync_err <= 1'b0;
                        o_overrun  <= 1'b0;
                    end
                end
                WAIT_SYNC: begin
                    if (i_ce && i_sync) begin
                        r_state <= CAPTURE;
                        r_wptr  <= LGFFT'(1);
                    end
                end
                CAPTURE: begin
                    // A sync mid-frame restarts the capture on the new frame.
                    if (i_ce && i_sync) begin
                        if (r_wptr != '0) begin
                            o_sync_err <= 1'b1;
                        end
                        r_wptr <= LGFFT'(1);
                    end else if (i_ce) begin
                        if (r_wptr == LAST_ADDR) begin
                            r_state      <= DRAIN;
                            r_wptr       <= '0;
                            r_k          <= '0;
                            r_fetch_done <= 1'b0;
                        end else begin
                            r_wptr <= r_wptr + LGFFT'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (i_ce && i_sync) begin
                        o_overrun <= 1'b1;
                    end
                    if (w_fetch) begin
                        o_tdata  <= r_mem[w_raddr];
                        o_tvalid <= 1'b1;
                        o_tlast  <= (r_k == LAST_ADDR);
                        r_k      <= r_k + LGFFT'(1);
                        if (r_k == LAST_ADDR) begin
                            r_fetch_done <= 1'b1;
                        end
                    end else if (w_xfer) begin
                        o_tvalid      <= 1'b0;
                        o_tlast       <= 1'b0;
                        o_busy        <= 1'b0;
                        r_state       <= IDLE;
                        o_frame_count <= o_frame_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_result_capture.sv
// Bench for fft_result_capture: natural-order and bit-reversed instances share
// stimulus; expected frames come from a stream-level capture model.
module tb_fft_result_capture;
    localparam int OW    = 20;
    localparam int LGFFT = 6;
    localparam int N     = 64;
    localparam int DW    = 2 * OW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm   = 1'b0;
    logic          ce    = 1'b0;
    logic          sync  = 1'b0;
    logic          tready = 1'b0;
    logic [DW-1:0] result = '0;

    logic          tvalid [2];
    logic          tlast  [2];
    logic          busy   [2];
    logic          serr   [2];
    logic          ovr    [2];
    logic [DW-1:0] tdata  [2];
    logic [15:0]   fcnt   [2];

    always #5 clk = ~clk;

    fft_result_capture #(.OW(OW), .LGFFT(LGFFT), .BITREV(0)) dut0 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_arm(arm), .i_ce(ce),
        .i_result(result), .i_sync(sync), .o_tvalid(tvalid[0]), .i_tready(tready),
        .o_tdata(tdata[0]), .o_tlast(tlast[0]), .o_busy(busy[0]),
        .o_sync_err(serr[0]), .o_overrun(ovr[0]), .o_frame_count(fcnt[0])
    );

    fft_result_capture #(.OW(OW), .LGFFT(LGFFT), .BITREV(1)) dut1 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_arm(arm), .i_ce(ce),
        .i_result(result), .i_sync(sync), .o_tvalid(tvalid[1]), .i_tready(tready),
        .o_tdata(tdata[1]), .o_tlast(tlast[1]), .o_busy(busy[1]),
        .o_sync_err(serr[1]), .o_overrun(ovr[1]), .o_frame_count(fcnt[1])
    );

    typedef struct {
        logic [DW-1:0] d;
        bit            s;
    } samp_t;

    typedef struct {
        bit seq;
        int restart_at;
        int gap_max;
        int ready_mode;
        bit inject_ovr;
        bit arm_last;
        bit exp_serr;
        bit exp_ovr;
    } scen_t;

    samp_t         stream [$];
    logic [DW-1:0] exp_frame [N];
    int            exp_used;
    int            exp_fcnt = 0;
    int            n_tests  = 0;
    int            n_fail   = 0;
    scen_t         tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < LGFFT; i++) begin
            if (((k >> i) & 1) != 0) r |= 1 << (LGFFT - 1 - i);
        end
        return r;
    endfunction

    task automatic gen_stream(input bit seq, input int restart_at);
        stream.delete();
        repeat ($urandom_range(0, 3)) stream.push_back('{d: DW'({$urandom(), $urandom()}), s: 1'b0});
        for (int j = 0; j < N + restart_at; j++) begin
            stream.push_back('{d: seq ? DW'(j) : DW'({$urandom(), $urandom()}),
                               s: (j == 0) || (restart_at != 0 && j == restart_at)});
        end
    endtask

    // Frame = the N samples following the most recent sync seen after arming.
    task automatic build_model();
        logic [DW-1:0] q [$];
        bit started = 1'b0;
        bit done = 1'b0;
        exp_used = 0;
        for (int i = 0; i < stream.size() && !done; i++) begin
            exp_used = i + 1;
            if (stream[i].s) begin
                started = 1'b1;
                q.delete();
                q.push_back(stream[i].d);
            end else if (started) begin
                q.push_back(stream[i].d);
            end
            if (q.size() == N) done = 1'b1;
        end
        for (int i = 0; i < N; i++) exp_frame[i] = (i < q.size()) ? q[i] : '0;
    endtask

    task automatic drive_stream(input int gap_max, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                ce = 1'b0; sync = 1'b0; result = DW'({$urandom(), $urandom()});
                @(negedge clk);
            end
            ce = 1'b1; sync = stream[i].s; result = stream[i].d;
            @(negedge clk);
        end
        ce = 1'b0; sync = 1'b0;
    endtask

    // Arm, capture a frame and check the drain start latency.
    task automatic capture(input scen_t s);
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d busy after arm", d), 64'(busy[d]), 64'd1);
            check($sformatf("d%0d sync_err cleared", d), 64'(serr[d]), 64'd0);
            check($sformatf("d%0d overrun cleared", d), 64'(ovr[d]), 64'd0);
        end
        gen_stream(s.seq, s.restart_at);
        build_model();
        drive_stream(s.gap_max, exp_used);
        for (int d = 0; d < 2; d++) check($sformatf("d%0d tvalid +1", d), 64'(tvalid[d]), 64'd0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check($sformatf("d%0d tvalid +2", d), 64'(tvalid[d]), 64'd1);
    endtask

    task automatic drain(input int mode, input bit inject, input bit arm_last, input int stop_at);
        int k [2] = '{0, 0};
        bit pstall [2] = '{1'b0, 1'b0};
        logic [DW-1:0] pd [2];
        logic pl [2];
        int cyc = 0;
        bit stop = 1'b0;
        bit r;
        while (!stop && (k[0] < N || k[1] < N) && cyc < 2000) begin
            for (int d = 0; d < 2; d++) begin
                if (pstall[d]) begin
                    check($sformatf("d%0d hold valid k%0d", d, k[d]), 64'(tvalid[d]), 64'd1);
                    check($sformatf("d%0d hold data k%0d", d, k[d]), 64'(tdata[d]), 64'(pd[d]));
                    check($sformatf("d%0d hold last k%0d", d, k[d]), 64'(tlast[d]), 64'(pl[d]));
                end
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            tready = r;
            ce     = inject && (cyc == 5);
            sync   = inject && (cyc == 5);
            result = DW'({$urandom(), $urandom()});
            for (int d = 0; d < 2; d++) begin
                pstall[d] = tvalid[d] && !r;
                pd[d] = tdata[d];
                pl[d] = tlast[d];
                if (tvalid[d] && r) begin
                    check($sformatf("d%0d beat%0d data", d, k[d]), 64'(tdata[d]),
                          64'(exp_frame[(d == 1) ? brev(k[d]) : k[d]]));
                    check($sformatf("d%0d beat%0d last", d, k[d]), 64'(tlast[d]), 64'(k[d] == N - 1));
                    k[d]++;
                end
            end
            if (arm_last && k[0] == N) arm = 1'b1;
            if (stop_at >= 0 && k[0] == stop_at) begin
                stop = 1'b1;
            end else begin
                @(negedge clk);
                arm = 1'b0;
                cyc++;
            end
        end
        if (!stop) begin
            tready = 1'b0;
            for (int d = 0; d < 2; d++) check($sformatf("d%0d beat count", d), 64'(k[d]), 64'(N));
            if (mode == 0) check("drain cycles", 64'(cyc), 64'(N));
        end
    endtask

    task automatic run_scen(input scen_t s);
        capture(s);
        drain(s.ready_mode, s.inject_ovr, s.arm_last, -1);
        exp_fcnt++;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d tvalid after last", d), 64'(tvalid[d]), 64'd0);
            check($sformatf("d%0d tlast after last", d), 64'(tlast[d]), 64'd0);
            check($sformatf("d%0d busy after last", d), 64'(busy[d]), 64'd0);
            check($sformatf("d%0d frame_count", d), 64'(fcnt[d]), 64'(16'(exp_fcnt)));
            check($sformatf("d%0d sync_err", d), 64'(serr[d]), 64'(s.exp_serr));
            check($sformatf("d%0d overrun", d), 64'(ovr[d]), 64'(s.exp_ovr));
        end
        if (s.arm_last) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) check($sformatf("d%0d arm on last ignored", d), 64'(busy[d]), 64'd0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d tvalid", tag, d), 64'(tvalid[d]), 64'd0);
            check($sformatf("%s d%0d tdata", tag, d), 64'(tdata[d]), 64'd0);
            check($sformatf("%s d%0d tlast", tag, d), 64'(tlast[d]), 64'd0);
            check($sformatf("%s d%0d busy", tag, d), 64'(busy[d]), 64'd0);
            check($sformatf("%s d%0d sync_err", tag, d), 64'(serr[d]), 64'd0);
            check($sformatf("%s d%0d overrun", tag, d), 64'(ovr[d]), 64'd0);
            check($sformatf("%s d%0d frame_count", tag, d), 64'(fcnt[d]), 64'd0);
        end
    endtask

    initial begin
        scen_t s;
        //        seq restart gap ready ovr armlast exp_serr exp_ovr
        tbl[0] = '{1'b1, 0,  0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 0,  0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 10, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 0,  3, 2, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 0,  2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 30, 2, 2, 1'b1, 1'b0, 1'b1, 1'b1};

        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_scen(tbl[i]);

        for (int i = 0; i < 4; i++) begin
            s.seq        = 1'b0;
            s.restart_at = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 60)) : 0;
            s.gap_max    = int'($urandom_range(0, 3));
            s.ready_mode = int'($urandom_range(0, 2));
            s.inject_ovr = 1'($urandom_range(0, 1));
            s.arm_last   = 1'b0;
            s.exp_serr   = (s.restart_at != 0);
            s.exp_ovr    = s.inject_ovr;
            run_scen(s);
        end

        // Reset in the middle of a drain abandons the frame.
        s = tbl[4];
        capture(s);
        drain(0, 1'b0, 1'b0, 20);
        #2 rst_n = 1'b0;
        tready = 1'b0;
        #1 check_reset_vals("mid-drain reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post-reset idle valid %0d", i), 64'(tvalid[0]), 64'd0);
            check($sformatf("post-reset idle busy %0d", i), 64'(busy[1]), 64'd0);
        end
        exp_fcnt = 0;
        run_scen(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end
endmodule
